// File: rtl/controlador_cajero.sv
// controlador_cajero: ATM card-session controller holding one account balance.
// Checks a 4-digit BCD PIN, counts failed attempts up to a lock-out, and runs
// one deposit or withdrawal per card session, with an optional per-transaction fee.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   tarjeta_recibida      card present (level)
//   tipo_tarjeta          1 = fee-charging card (latched at session start)
//   pin[15:0]             correct PIN, 4 BCD digits, [15:12] entered first
//   digito, digito_stb    entered digit and its strobe (edge-detected)
//   tipo_transaccion      0 = deposit, 1 = withdrawal (sampled with monto)
//   monto, monto_stb      amount and its strobe (edge-detected)
//   balance_actualizado   pulse: balance written
//   entregar_dinero       pulse: withdrawal granted
//   fondos_insuficientes  pulse: withdrawal rejected
//   pin_incorrecto        pulse: wrong PIN
//   advertencia, bloqueo  levels: 2nd / 3rd wrong PIN
//   comision              pulse: fee deducted
//   saldo                 current balance
module controlador_cajero #(
  parameter longint unsigned BALANCE_INICIAL = 50000,
  parameter int unsigned     COMISION_MONTO  = 100,
  parameter int unsigned     ANCHO_BALANCE   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tarjeta_recibida,
  input  logic                     tipo_tarjeta,
  input  logic [15:0]              pin,
  input  logic [3:0]               digito,
  input  logic                     digito_stb,
  input  logic                     tipo_transaccion,
  input  logic [31:0]              monto,
  input  logic                     monto_stb,
  output logic                     balance_actualizado,
  output logic                     entregar_dinero,
  output logic                     fondos_insuficientes,
  output logic                     pin_incorrecto,
  output logic                     advertencia,
  output logic                     bloqueo,
  output logic                     comision,
  output logic [ANCHO_BALANCE-1:0] saldo
);

  localparam int unsigned W  = ANCHO_BALANCE;
  localparam int unsigned WX = ANCHO_BALANCE + 1;

  typedef enum logic [2:0] {
    IDLE,
    PIN,
    CHECK,
    TRANS,
    EXEC,
    FIN,
    BLOQUEO
  } estado_t;

  estado_t         estado_q, estado_d;
  logic            dstb_q, dstb_d;
  logic            mstb_q, mstb_d;
  logic [15:0]     pin_ref_q, pin_ref_d;
  logic            tipo_tarj_q, tipo_tarj_d;
  logic [15:0]     digitos_q, digitos_d;
  logic [1:0]      cuenta_q, cuenta_d;
  logic [1:0]      intentos_q, intentos_d;
  logic            advert_q, advert_d;
  logic            bloq_q, bloq_d;
  logic            tipo_tx_q, tipo_tx_d;
  logic [31:0]     monto_q, monto_d;
  logic [W-1:0]    saldo_q, saldo_d;
  logic            bal_act_q, bal_act_d;
  logic            entregar_q, entregar_d;
  logic            fondos_q, fondos_d;
  logic            pin_inc_q, pin_inc_d;
  logic            comision_q, comision_d;

  logic            dig_ev, mon_ev;
  logic [WX-1:0]   fee;
  logic [WX-1:0]   suma;
  logic [WX-1:0]   dif;
  logic [W-1:0]    deposito_res;
  logic [WX-1:0]   necesario;
  logic            retiro_ok;
  logic [W-1:0]    retiro_res;

  always_comb begin
    dig_ev = digito_stb & ~dstb_q;
    mon_ev = monto_stb & ~mstb_q;

    fee = tipo_tarj_q ? WX'(COMISION_MONTO) : '0;

    // Deposit in W+1 bits: floor at 0 when the fee exceeds saldo+monto,
    // saturate when the carry bit of the result is set.
    suma = WX'(saldo_q) + WX'(monto_q);
    dif  = suma - fee;
    if (suma < fee) begin
      deposito_res = '0;
    end else if (dif[W]) begin
      deposito_res = '1;
    end else begin
      deposito_res = dif[W-1:0];
    end

    necesario  = WX'(monto_q) + fee;
    retiro_ok  = ({1'b0, saldo_q} >= necesario);
    retiro_res = saldo_q - necesario[W-1:0];
  end

  always_comb begin
    estado_d    = estado_q;
    dstb_d      = digito_stb;
    mstb_d      = monto_stb;
    pin_ref_d   = pin_ref_q;
    tipo_tarj_d = tipo_tarj_q;
    digitos_d   = digitos_q;
    cuenta_d    = cuenta_q;
    intentos_d  = intentos_q;
    advert_d    = advert_q;
    bloq_d      = bloq_q;
    tipo_tx_d   = tipo_tx_q;
    monto_d     = monto_q;
    saldo_d     = saldo_q;
    bal_act_d   = 1'b0;
    entregar_d  = 1'b0;
    fondos_d    = 1'b0;
    pin_inc_d   = 1'b0;
    comision_d  = 1'b0;

    unique case (estado_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          pin_ref_d   = pin;
          tipo_tarj_d = tipo_tarjeta;
          cuenta_d    = '0;
          estado_d    = PIN;
        end
      end
      PIN: begin
        if (!tarjeta_recibida) begin
          estado_d = IDLE;
        end else if (dig_ev) begin
          digitos_d = {digitos_q[11:0], digito};
          cuenta_d  = cuenta_q + 2'd1;
          if (cuenta_q == 2'd3) estado_d = CHECK;
        end
      end
      CHECK: begin
        if (!tarjeta_recibida) begin
          estado_d = IDLE;
        end else if (digitos_q == pin_ref_q) begin
          intentos_d = '0;
          advert_d   = 1'b0;
          estado_d   = TRANS;
        end else begin
          pin_inc_d  = 1'b1;
          intentos_d = intentos_q + 2'd1;
          if (intentos_d == 2'd2) advert_d = 1'b1;
          if (intentos_d == 2'd3) begin
            bloq_d   = 1'b1;
            estado_d = BLOQUEO;
          end else begin
            cuenta_d = '0;
            estado_d = PIN;
          end
        end
      end
      TRANS: begin
        if (!tarjeta_recibida) begin
          estado_d = IDLE;
        end else if (mon_ev) begin
          tipo_tx_d = tipo_transaccion;
          monto_d   = monto;
          estado_d  = EXEC;
        end
      end
      // Captured transaction is committed one cycle after capture so that
      // saldo and every pulse register update on the same edge.
      EXEC: begin
        if (!tipo_tx_q) begin
          saldo_d    = deposito_res;
          bal_act_d  = 1'b1;
          comision_d = (fee != '0);
        end else if (retiro_ok) begin
          saldo_d    = retiro_res;
          bal_act_d  = 1'b1;
          entregar_d = 1'b1;
          comision_d = (fee != '0);
        end else begin
          fondos_d   = 1'b1;
        end
        estado_d = FIN;
      end
      FIN: begin
        if (!tarjeta_recibida) estado_d = IDLE;
      end
      BLOQUEO: begin
        estado_d = BLOQUEO;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= IDLE;
      dstb_q      <= 1'b0;
      mstb_q      <= 1'b0;
      pin_ref_q   <= '0;
      tipo_tarj_q <= 1'b0;
      digitos_q   <= '0;
      cuenta_q    <= '0;
      intentos_q  <= '0;
      advert_q    <= 1'b0;
      bloq_q      <= 1'b0;
      tipo_tx_q   <= 1'b0;
      monto_q     <= '0;
      saldo_q     <= W'(BALANCE_INICIAL);
      bal_act_q   <= 1'b0;
      entregar_q  <= 1'b0;
      fondos_q    <= 1'b0;
      pin_inc_q   <= 1'b0;
      comision_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      dstb_q      <= dstb_d;
      mstb_q      <= mstb_d;
      pin_ref_q   <= pin_ref_d;
      tipo_tarj_q <= tipo_tarj_d;
      digitos_q   <= digitos_d;
      cuenta_q    <= cuenta_d;
      intentos_q  <= intentos_d;
      advert_q    <= advert_d;
      bloq_q      <= bloq_d;
      tipo_tx_q   <= tipo_tx_d;
      monto_q     <= monto_d;
      saldo_q     <= saldo_d;
      bal_act_q   <= bal_act_d;
      entregar_q  <= entregar_d;
      fondos_q    <= fondos_d;
      pin_inc_q   <= pin_inc_d;
      comision_q  <= comision_d;
    end
  end

  assign balance_actualizado  = bal_act_q;
  assign entregar_dinero      = entregar_q;
  assign fondos_insuficientes = fondos_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = advert_q;
  assign bloqueo              = bloq_q;
  assign comision             = comision_q;
  assign saldo                = saldo_q;

endmodule

// File: tb/tb_controlador_cajero.sv
// Directed testbench for controlador_cajero (default parameters).
module tb_controlador_cajero;

  logic        clk;
  logic        rst;
  logic        tarjeta_recibida;
  logic        tipo_tarjeta;
  logic [15:0] pin;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        tipo_transaccion;
  logic [31:0] monto;
  logic        monto_stb;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        comision;
  logic [63:0] saldo;

  int checks   = 0;
  int failures = 0;

  // cycles-high counters for each pulse output, sampled on the falling edge
  int n_bal = 0, n_ent = 0, n_fon = 0, n_pin = 0, n_com = 0;
  int s_bal, s_ent, s_fon, s_pin, s_com;

  controlador_cajero #(
    .BALANCE_INICIAL(50000),
    .COMISION_MONTO (100),
    .ANCHO_BALANCE  (64)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tarjeta_recibida    (tarjeta_recibida),
    .tipo_tarjeta        (tipo_tarjeta),
    .pin                 (pin),
    .digito              (digito),
    .digito_stb          (digito_stb),
    .tipo_transaccion    (tipo_transaccion),
    .monto               (monto),
    .monto_stb           (monto_stb),
    .balance_actualizado (balance_actualizado),
    .entregar_dinero     (entregar_dinero),
    .fondos_insuficientes(fondos_insuficientes),
    .pin_incorrecto      (pin_incorrecto),
    .advertencia         (advertencia),
    .bloqueo             (bloqueo),
    .comision            (comision),
    .saldo               (saldo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_bal = n_bal + int'(balance_actualizado);
    n_ent = n_ent + int'(entregar_dinero);
    n_fon = n_fon + int'(fondos_insuficientes);
    n_pin = n_pin + int'(pin_incorrecto);
    n_com = n_com + int'(comision);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_bal = n_bal; s_ent = n_ent; s_fon = n_fon; s_pin = n_pin; s_com = n_com;
  endtask

  task automatic do_reset();
    tarjeta_recibida = 1'b0;
    digito_stb       = 1'b0;
    monto_stb        = 1'b0;
    rst              = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic card_in(input logic [15:0] p, input logic t);
    pin              = p;
    tipo_tarjeta     = t;
    tarjeta_recibida = 1'b1;
    tick();
  endtask

  task automatic card_out();
    tarjeta_recibida = 1'b0;
    tick();
  endtask

  task automatic digit(input logic [3:0] d, input int hold);
    digito     = d;
    digito_stb = 1'b1;
    repeat (hold) tick();
    digito_stb = 1'b0;
    tick();
  endtask

  task automatic enter(input logic [15:0] code, input int hold);
    for (int i = 0; i < 4; i++) digit(code[15-4*i -: 4], hold);
  endtask

  task automatic tx(input logic t, input logic [31:0] amt);
    tipo_transaccion = t;
    monto            = amt;
    monto_stb        = 1'b1;
    tick();
    monto_stb = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0; tarjeta_recibida = 1'b0; tipo_tarjeta = 1'b0; pin = '0;
    digito = '0; digito_stb = 1'b0; tipo_transaccion = 1'b0; monto = '0; monto_stb = 1'b0;

    // Reset state
    do_reset();
    check("reset_flags", 64'({balance_actualizado, entregar_dinero, fondos_insuficientes,
                              pin_incorrecto, advertencia, bloqueo, comision}), 64'd0);
    check("reset_saldo", saldo, 64'd50000);

    // 1: PIN 6533, fee card, deposit 2000 -> 51900, exact pulse timing
    snap();
    card_in(16'h6533, 1'b1);
    enter(16'h6533, 1);
    check("t1_no_pin_err", 64'(n_pin - s_pin), 64'd0);
    tipo_transaccion = 1'b0; monto = 32'd2000; monto_stb = 1'b1;
    tick();
    check("t1_capture_no_pulse", 64'(balance_actualizado), 64'd0);
    monto_stb = 1'b0;
    tick();
    check("t1_bal_pulse", 64'(balance_actualizado), 64'd1);
    check("t1_com_pulse", 64'(comision), 64'd1);
    check("t1_saldo", saldo, 64'd51900);
    tick();
    check("t1_pulses_end", 64'({balance_actualizado, comision}), 64'd0);
    tx(1'b0, 32'd5000); // second amount in FIN is ignored
    check("t1_fin_ignores", saldo, 64'd51900);
    check("t1_bal_once", 64'(n_bal - s_bal), 64'd1);
    card_out();

    // 2: two wrong PINs, then correct, no-fee deposit 20000
    do_reset();
    snap();
    card_in(16'h2222, 1'b0);
    enter(16'h6533, 1);
    check("t2_pin_err1", 64'(n_pin - s_pin), 64'd1);
    check("t2_adv_after1", 64'(advertencia), 64'd0);
    enter(16'h1233, 1);
    check("t2_pin_err2", 64'(n_pin - s_pin), 64'd2);
    check("t2_adv_after2", 64'(advertencia), 64'd1);
    enter(16'h2222, 1);
    check("t2_adv_cleared", 64'(advertencia), 64'd0);
    tx(1'b0, 32'd20000);
    check("t2_saldo", saldo, 64'd70000);
    check("t2_no_com", 64'(n_com - s_com), 64'd0);
    check("t2_bal_pulse", 64'(n_bal - s_bal), 64'd1);
    card_out();

    // 3: insufficient funds
    do_reset();
    snap();
    card_in(16'h1123, 1'b0);
    enter(16'h1123, 1);
    tx(1'b1, 32'd60000);
    check("t3_fondos", 64'(n_fon - s_fon), 64'd1);
    check("t3_saldo", saldo, 64'd50000);
    check("t3_no_entregar", 64'(n_ent - s_ent), 64'd0);
    check("t3_no_bal", 64'(n_bal - s_bal), 64'd0);
    card_out();

    // 4: fee-card withdrawal 20000 -> 29900
    do_reset();
    snap();
    card_in(16'h1123, 1'b1);
    enter(16'h1123, 1);
    tx(1'b1, 32'd20000);
    check("t4_entregar", 64'(n_ent - s_ent), 64'd1);
    check("t4_bal", 64'(n_bal - s_bal), 64'd1);
    check("t4_com", 64'(n_com - s_com), 64'd1);
    check("t4_saldo", saldo, 64'd29900);
    card_out();

    // 5: lock-out; abort keeps attempts and advertencia
    do_reset();
    snap();
    card_in(16'h4444, 1'b0);
    enter(16'h1111, 1);
    enter(16'h1112, 1);
    check("t5_adv", 64'(advertencia), 64'd1);
    card_out();
    check("t5_adv_kept", 64'(advertencia), 64'd1);
    card_in(16'h4444, 1'b0);
    enter(16'h1113, 1);
    check("t5_bloqueo", 64'(bloqueo), 64'd1);
    check("t5_pin_err3", 64'(n_pin - s_pin), 64'd3);
    enter(16'h4444, 1);
    tx(1'b0, 32'd1000);
    check("t5_locked_saldo", saldo, 64'd50000);
    check("t5_locked_no_bal", 64'(n_bal - s_bal), 64'd0);
    check("t5_locked_no_pin", 64'(n_pin - s_pin), 64'd3);
    card_out();
    card_in(16'h4444, 1'b0);
    check("t5_still_locked", 64'(bloqueo), 64'd1);
    do_reset();
    check("t5_rst_unlock", 64'({bloqueo, advertencia}), 64'd0);
    check("t5_rst_saldo", saldo, 64'd50000);

    // 6: held strobes count once; reset mid-PIN restarts digit count
    snap();
    card_in(16'h4567, 1'b0);
    enter(16'h4567, 3);
    check("t6_held_no_err", 64'(n_pin - s_pin), 64'd0);
    tx(1'b0, 32'd500);
    check("t6_held_saldo", saldo, 64'd50500);
    card_out();
    card_in(16'h9876, 1'b0);
    digit(4'h9, 1);
    digit(4'h8, 1);
    do_reset();
    snap();
    card_in(16'h9876, 1'b0);
    enter(16'h9876, 1);
    check("t6_rst_no_err", 64'(n_pin - s_pin), 64'd0);
    tx(1'b0, 32'd10);
    check("t6_rst_saldo", saldo, 64'd50010);
    card_out();

    // 7: exact-balance withdrawal, then deposit below fee floors at 0
    do_reset();
    snap();
    card_in(16'h0000, 1'b1);
    enter(16'h0000, 1);
    tx(1'b1, 32'd49900);
    check("t7_exact_saldo", saldo, 64'd0);
    check("t7_exact_entregar", 64'(n_ent - s_ent), 64'd1);
    card_out();
    snap();
    card_in(16'h0000, 1'b1);
    enter(16'h0000, 1);
    tx(1'b0, 32'd50);
    check("t7_floor_saldo", saldo, 64'd0);
    check("t7_floor_bal", 64'(n_bal - s_bal), 64'd1);
    check("t7_floor_com", 64'(n_com - s_com), 64'd1);
    card_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_cajero.md
# controlador_cajero

ATM card-session controller: the responder that consumes the card, PIN-digit and transaction stimulus produced by the team's ATM bench, and drives the account-status outputs. It holds one account balance. It checks a 4-digit BCD PIN entered one digit at a time, counts failed attempts up to a lock-out, and executes one deposit or withdrawal per card session, including an optional commission.

## Interface
Parameters:
- BALANCE_INICIAL, 50000: balance loaded on reset.
- COMISION_MONTO, 100: fee charged per transaction when tipo_tarjeta=1.
- ANCHO_BALANCE, 64: balance register width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tarjeta_recibida  in  1  card present (level).
- tipo_tarjeta  in  1  1 = commission-charging card; latched at session start.
- pin  in  16  correct PIN as 4 BCD digits; pin[15:12] is entered first. Latched at session start.
- digito  in  4  entered digit; valid on the rising edge of digito_stb.
- digito_stb  in  1  digit strobe (level; may stay high for several cycles).
- tipo_transaccion  in  1  0 = deposit, 1 = withdrawal; sampled with monto.
- monto  in  32  transaction amount, unsigned.
- monto_stb  in  1  amount strobe (level).
- balance_actualizado  out  1  one-cycle pulse when the balance is written.
- entregar_dinero  out  1  one-cycle pulse on a successful withdrawal.
- fondos_insuficientes  out  1  one-cycle pulse on a rejected withdrawal.
- pin_incorrecto  out  1  one-cycle pulse on each wrong PIN.
- advertencia  out  1  level; high after the 2nd wrong PIN.
- bloqueo  out  1  level; high after the 3rd wrong PIN.
- comision  out  1  one-cycle pulse when a fee is deducted.
- saldo  out  ANCHO_BALANCE  current balance (observability).

## Operation
- Strobe detection: digito_stb and monto_stb are registered. An event is a cycle where the strobe is 1 and its registered copy is 0. A level held high counts once.
- State IDLE: when tarjeta_recibida=1, latch pin and tipo_tarjeta, clear the digit count, and go to PIN.
- State PIN: on each digito_stb event, store digito and increment the count (0..3). After the 4th digit, go to CHECK.
- State CHECK: the compare takes one cycle.
  - On a match, clear the attempt counter, clear advertencia, and go to TRANS.
  - On a mismatch, pulse pin_incorrecto and increment the attempts counter (2 bits).
    - attempts==2: set advertencia.
    - attempts==3: set bloqueo and go to BLOQUEO.
    - Otherwise, return to PIN with the digit count cleared.
- State TRANS: on a monto_stb event, capture tipo_transaccion and monto. The fee is COMISION_MONTO if the latched tipo_tarjeta=1, else 0.
  - Deposit: saldo ← saldo + monto − fee, saturating at max and floored at 0. Pulse balance_actualizado, and pulse comision if fee≠0.
  - Withdrawal with saldo ≥ monto + fee (computed at ANCHO_BALANCE+1 bits): saldo ← saldo − monto − fee. Pulse balance_actualizado and entregar_dinero, and pulse comision if fee≠0.
  - Withdrawal otherwise: pulse fondos_insuficientes only. Balance is unchanged and no fee is charged.
  - Then go to FIN.
- State FIN: wait for tarjeta_recibida=0, then go to IDLE. Exactly one transaction per session.
- State BLOQUEO: all inputs are ignored. Only rst exits.
- tarjeta_recibida falling in PIN, CHECK or TRANS aborts the session to IDLE. The attempts counter and advertencia are retained; only rst clears them.
- rst at any time forces IDLE, attempts=0, saldo=BALANCE_INICIAL, and all pulse/level outputs 0. rst has priority over every other event in the same cycle.

## Timing
- Reset values: all 1-bit outputs 0; saldo=BALANCE_INICIAL.
- All outputs are registered. Pulses are exactly one clk cycle wide.
- Digit latency: a strobe rising before edge N is detected at edge N. The 4th digit enters CHECK at edge N. Outputs (pin_incorrecto, advertencia, bloqueo) change at edge N+1.
- Transaction latency: a monto_stb rising before edge M is captured at edge M. saldo and all pulses update together at edge M+1.
- Strobes arriving in any state other than PIN or TRANS are ignored and not queued. This includes a digito_stb during CHECK.
- A monto_stb and a digito_stb event in the same cycle: only the one valid for the current state is used.

## Test plan
- Correct PIN 6533, tipo_tarjeta=1, deposit 2000 -> saldo 51900; balance_actualizado and comision pulse one cycle, 2 cycles after the monto_stb rise.
- Two wrong PINs (6533, 1233) then correct 2222, tipo_tarjeta=0, deposit 20000:
  - pin_incorrecto pulses twice; advertencia high after the 2nd.
  - advertencia clears on the correct PIN; saldo 70000; comision stays 0.
- After rst, PIN 1123 correct, tipo_tarjeta=0, withdraw 60000 -> fondos_insuficientes pulse; saldo stays 50000; entregar_dinero stays 0.
- After rst, tipo_tarjeta=1, withdraw 20000 -> entregar_dinero, balance_actualizado and comision pulse; saldo 29900.
- Three wrong PINs -> bloqueo=1 and stays high; further digits and monto_stb cause no change; rst clears bloqueo and restores saldo 50000.
- digito_stb held high for 3 cycles per digit -> each digit counted once; rst asserted mid-PIN -> next session starts from digit 0.
